cntr8_sweeper: RTL and testbench



---
 rtl/cntr8_sweeper_if.sv | 23 ++
 rtl/cntr8_sweeper.sv | 77 +++++++
 tb/tb_cntr8_sweeper.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cntr8_sweeper_if.sv
// cntr8_sweeper_if: control and counter-command bundle between controller and sweeper
interface cntr8_sweeper_if #(parameter int WIDTH = 8, parameter int SWW = 4);
  logic             start;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [SWW-1:0]   n_sweeps;
  logic             load;
  logic             inc;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] cnt;
  logic             busy;
  logic             done;
  logic             err;
  logic [2:0]       o_state;
  modport master (
    output start, lo, hi, n_sweeps,
    input  load, inc, d_in, cnt, busy, done, err, o_state
  );
  modport slave (
    input  start, lo, hi, n_sweeps,
    output load, inc, d_in, cnt, busy, done, err, o_state
  );
endinterface

// File: rtl/cntr8_sweeper.sv
// cntr8_sweeper: drives an up/down counter to ping-pong between lo and hi for n sweeps
module cntr8_sweeper #(
  parameter int WIDTH = 8,
  parameter int SWW   = 4
) (
  input  logic           clk,
  input  logic           reset,
  cntr8_sweeper_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE = 3'b000,
    LOAD = 3'b001,
    UP   = 3'b010,
    DOWN = 3'b011,
    DONE = 3'b100
  } state_t;
  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] hi_r;
  logic [SWW-1:0]   sw_r;
  logic             err;
  logic [WIDTH-1:0] cnt_up;
  logic [WIDTH-1:0] cnt_dn;
  logic             reject;
  assign cnt_up = cnt + 1'b1;
  assign cnt_dn = cnt - 1'b1;
  assign reject = (bus.lo >= bus.hi) || (bus.n_sweeps == '0);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      lo_r  <= '0;
      hi_r  <= '0;
      sw_r  <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          lo_r  <= bus.lo;
          hi_r  <= bus.hi;
          sw_r  <= bus.n_sweeps;
          err   <= reject;
          state <= reject ? DONE : LOAD;
        end
        LOAD: begin
          cnt   <= lo_r;
          state <= UP;
        end
        UP: begin
          cnt <= cnt_up;
          if (cnt_up == hi_r) state <= DOWN;
        end
        DOWN: begin
          cnt <= cnt_dn;
          if (cnt_dn == lo_r) begin
            sw_r  <= sw_r - 1'b1;
            state <= (sw_r == SWW'(1)) ? DONE : UP;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // The counter has no hold input, so every non-stepping state reloads cnt.
  always_comb begin
    bus.load    = (state != UP) && (state != DOWN);
    bus.inc     = state != DOWN;
    bus.d_in    = (state == LOAD) ? lo_r : cnt;
    bus.cnt     = cnt;
    bus.busy    = (state == LOAD) || (state == UP) || (state == DOWN);
    bus.done    = state == DONE;
    bus.err     = err;
    bus.o_state = state;
  end
endmodule

// File: tb/tb_cntr8_sweeper.sv
// tb_cntr8_sweeper: table-driven runs against a behavioural 8-bit up/down counter
module tb_cntr8_sweeper;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  cntr8_sweeper_if #(.WIDTH(8), .SWW(4)) bus ();
  cntr8_sweeper #(.WIDTH(8), .SWW(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  logic [7:0] d_out;
  always @(posedge clk) d_out <= bus.load ? bus.d_in : (bus.inc ? d_out + 8'd1 : d_out - 8'd1);
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] n;
    bit         poke;
    logic       err;
    int         k;
    logic [7:0] fin;
  } vec_t;
  vec_t tbl [9];
  logic [7:0] seq [$];
  logic [7:0] exp_seq [13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input vec_t v, output int k);
    int mism;
    int rng;
    mism = 0;
    rng = 0;
    seq.delete();
    bus.lo = v.lo;
    bus.hi = v.hi;
    bus.n_sweeps = v.n;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    chk("accept_state", bus.o_state, v.err ? 3'd4 : 3'd1);
    chk("accept_err", bus.err, v.err);
    k = 0;
    forever begin
      if (k >= 1) seq.push_back(bus.cnt);
      if (d_out !== bus.cnt) mism++;
      if ((bus.o_state == 3'd2 || bus.o_state == 3'd3) && (bus.cnt < v.lo || bus.cnt > v.hi)) rng++;
      if (bus.done) break;
      if (k >= 300) begin
        chk("done_timeout", 1, 0);
        break;
      end
      if (v.poke && k == 2) begin
        bus.start = 1'b1;
        bus.lo = 8'd9;
        bus.hi = 8'd12;
        bus.n_sweeps = 4'd5;
      end
      step;
      bus.start = 1'b0;
      k++;
    end
    chk("done_k", k, v.k);
    chk("done_err", bus.err, v.err);
    chk("done_cnt", bus.cnt, v.fin);
    chk("done_load", bus.load, 1);
    chk("shadow_mismatches", mism, 0);
    chk("range_violations", rng, 0);
    step;
    chk("after_state", bus.o_state, 3'd0);
    chk("after_done", bus.done, 0);
    chk("after_cnt", bus.cnt, v.fin);
    chk("after_dout", d_out, v.fin);
  endtask
  initial begin
    int k;
    int dones;
    tbl[0] = '{8'd3,    8'd6,    4'd2, 1'b0, 1'b0, 13, 8'd3};
    tbl[1] = '{8'hFE,   8'hFF,   4'd1, 1'b0, 1'b0, 3,  8'hFE};
    tbl[2] = '{8'd7,    8'd7,    4'd1, 1'b0, 1'b1, 0,  8'hFE};
    tbl[3] = '{8'd2,    8'd5,    4'd0, 1'b0, 1'b1, 0,  8'hFE};
    tbl[4] = '{8'd0,    8'd4,    4'd1, 1'b0, 1'b0, 9,  8'd0};
    tbl[5] = '{8'd9,    8'd8,    4'd1, 1'b0, 1'b1, 0,  8'd0};
    tbl[6] = '{8'd0,    8'd4,    4'd1, 1'b1, 1'b0, 9,  8'd0};
    tbl[7] = '{8'd10,   8'd20,   4'd3, 1'b0, 1'b0, 61, 8'd10};
    tbl[8] = '{8'h80,   8'h82,   4'd2, 1'b0, 1'b0, 9,  8'h80};
    exp_seq = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd5, 8'd4, 8'd3, 8'd4, 8'd5, 8'd6, 8'd5, 8'd4, 8'd3};
    bus.start = 1'b0;
    bus.lo = '0;
    bus.hi = '0;
    bus.n_sweeps = '0;
    reset = 1'b1;
    step;
    step;
    chk("rst_state", bus.o_state, 3'd0);
    chk("rst_load", bus.load, 1);
    chk("rst_inc", bus.inc, 1);
    chk("rst_din", bus.d_in, 0);
    chk("rst_cnt", bus.cnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    reset = 1'b0;
    step;
    for (int i = 0; i < 9; i++) begin
      run(tbl[i], k);
      if (i == 0) begin
        chk("seq_len", seq.size(), 13);
        for (int j = 0; j < 13 && j < seq.size(); j++) chk($sformatf("seq_%0d", j), seq[j], exp_seq[j]);
      end
    end
    bus.lo = 8'd3;
    bus.hi = 8'd9;
    bus.n_sweeps = 4'd1;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    step;
    step;
    step;
    chk("midrun_state", bus.o_state, 3'd2);
    chk("midrun_cnt", bus.cnt, 8'd5);
    dones = 0;
    reset = 1'b1;
    step;
    if (bus.done) dones++;
    chk("abort_state", bus.o_state, 3'd0);
    chk("abort_load", bus.load, 1);
    chk("abort_din", bus.d_in, 0);
    chk("abort_cnt", bus.cnt, 0);
    chk("abort_busy", bus.busy, 0);
    step;
    if (bus.done) dones++;
    reset = 1'b0;
    step;
    if (bus.done) dones++;
    chk("abort_no_done", dones, 0);
    chk("abort_dout", d_out, 0);
    chk("abort_idle", bus.o_state, 3'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
